// File: rtl/updown_counter_gen2_pkg.sv
// Shared types and helpers for the second-generation up/down LED counter.
// Counting modes and the prescaler width rule live here so every file agrees on them.
package updown_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'd0,
    MODE_SAT    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } cnt_mode_t;

  // A divide-by-1 prescaler still needs one flop bit to stay a legal vector.
  function automatic int presc_width(input int div);
    int w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/updown_counter_gen2_if.sv
// Control/status bundle between the board top (master) and the counter (slave).
interface updown_counter_gen2_if #(
  parameter int WIDTH = 4
);
  import updown_counter_pkg::*;

  logic             enable;
  logic             dir;
  cnt_mode_t        mode;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             dir_out;
  logic             cfg_err;

  modport master (
    output enable, dir, mode, lo, hi, load, load_val,
    input  count, tc, dir_out, cfg_err
  );

  modport slave (
    input  enable, dir, mode, lo, hi, load, load_val,
    output count, tc, dir_out, cfg_err
  );

endinterface

// File: rtl/updown_counter_gen2_prescaler.sv
// Enable-gated clock divider: pulses tick once every DIV enabled cycles.
// clr restarts the division so a parallel load begins a fresh step period.
module prescaler_tick
  import updown_counter_pkg::*;
#(
  parameter int DIV = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = presc_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;

  assign tick = enable && (presc_q == LAST);

  always_comb begin
    // NOTE: every path starts from a default so no latch is inferred.
    presc_d = presc_q;
    if (clr || tick) begin
      presc_d = '0;
    end else if (enable) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: flops use <= so each one samples the pre-edge value of the others.
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/updown_counter_gen2.sv
// Up/down counter with programmable limits, wrap/saturate/bounce modes,
// parallel load and a one-cycle terminal-count pulse; count feeds the LEDs.
module updown_counter_gen2
  import updown_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  updown_counter_gen2_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             tick;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             dir_q, dir_d;
  logic             cfg_err_q, cfg_err_d;

  prescaler_tick #(.DIV(DIV)) u_presc (
    .clk    (clk),
    .reset  (reset),
    .enable (bus.enable),
    .clr    (bus.load),
    .tick   (tick)
  );

  always_comb begin
    count_d   = count_q;
    tc_d      = 1'b0;
    cfg_err_d = (bus.lo > bus.hi);
    // Outside BOUNCE the status just follows the dir pin; inside it is the bounce state.
    dir_d     = (bus.mode == MODE_BOUNCE) ? dir_q : bus.dir;

    if (bus.load) begin
      count_d = bus.load_val;
    end else if (tick && !cfg_err_q && bus.mode != MODE_HOLD) begin
      if (count_q < bus.lo) begin
        count_d = bus.lo;
        tc_d    = 1'b1;
      end else if (count_q > bus.hi) begin
        count_d = bus.hi;
        tc_d    = 1'b1;
      end else begin
        unique case (bus.mode)
          MODE_WRAP: begin
            if (bus.dir) begin
              if (count_q == bus.hi) begin
                count_d = bus.lo;
                tc_d    = 1'b1;
              end else begin
                count_d = count_q + ONE;
              end
            end else if (count_q == bus.lo) begin
              count_d = bus.hi;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q - ONE;
            end
          end
          MODE_SAT: begin
            if (bus.dir) begin
              if (count_q == bus.hi) tc_d = 1'b1;
              else                   count_d = count_q + ONE;
            end else begin
              if (count_q == bus.lo) tc_d = 1'b1;
              else                   count_d = count_q - ONE;
            end
          end
          MODE_BOUNCE: begin
            // A single-value window has nowhere to go, so only the direction turns.
            if (bus.lo == bus.hi) begin
              dir_d = ~dir_q;
              tc_d  = 1'b1;
            end else if (dir_q) begin
              if (count_q == bus.hi) begin
                count_d = bus.hi - ONE;
                dir_d   = 1'b0;
                tc_d    = 1'b1;
              end else begin
                count_d = count_q + ONE;
              end
            end else if (count_q == bus.lo) begin
              count_d = bus.lo + ONE;
              dir_d   = 1'b1;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q - ONE;
            end
          end
          default: begin
            count_d = count_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      tc_q      <= 1'b0;
      dir_q     <= 1'b1;
      cfg_err_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      tc_q      <= tc_d;
      dir_q     <= dir_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.dir_out = dir_q;
  assign bus.cfg_err = cfg_err_q;

endmodule
